// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: maps the core's pc to an 8-bit instruction.
// Keeps one demand entry (cur) and one sequential prefetch entry (pf), and
// talks to instruction memory over a single-outstanding req/ack handshake.
// Ports:
//   clk, CLB            clock (rising edge) and asynchronous active-low reset
//   pc                  program counter from the core
//   ins_out, ins_valid  instruction for the core and its match to pc
//   stall               inverse of ins_valid
//   mem_req, mem_addr   registered memory request and address
//   mem_ack, mem_data   memory completion strobe and read data
//   err                 sticky timeout flag
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [7:0]  NOP_INS     = 8'h00,
    parameter bit          PREFETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       CLB,
    input  logic [7:0] pc,
    output logic [7:0] ins_out,
    output logic       ins_valid,
    output logic       stall,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic       err
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PREF  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    entry_t        cur_q, cur_d, pf_q, pf_d;
    logic          req_d;
    logic [AW-1:0] addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_d;
    logic [DW-1:0] hold_q;

    logic          cur_hit, pf_hit, timeout_hit, pf_has_next;
    logic [AW-1:0] pc_next;

    // Hit detection is purely combinational from stored entries and pc
    assign cur_hit   = cur_q.valid && (cur_q.addr == pc);
    assign pf_hit    = pf_q.valid && (pf_q.addr == pc);
    assign ins_valid = cur_hit || pf_hit;
    assign stall     = !ins_valid;
    assign ins_out   = cur_hit ? cur_q.data : (pf_hit ? pf_q.data : hold_q);

    // 8-bit wrap is intentional: pc 8'hFF prefetches 8'h00
    assign pc_next     = pc + AW'(1);
    assign pf_has_next = pf_q.valid && (pf_q.addr == pc_next);

    // Final wait cycle of a stalled request; an ack in the same cycle wins
    assign timeout_hit = mem_req && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pf_d    = pf_q;
        req_d   = mem_req;
        addr_d  = mem_addr;
        cnt_d   = cnt_q;
        err_d   = err;

        // Promote a consumed prefetch to the demand entry
        if (pf_hit) begin
            cur_d       = pf_q;
            pf_d.valid  = 1'b0;
        end

        if (mem_req) begin
            if (mem_ack || timeout_hit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (!ins_valid) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = FETCH;
                end else if (PREFETCH_EN && !pf_has_next) begin
                    req_d   = 1'b1;
                    addr_d  = pc_next;
                    state_d = PREF;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    // Stale data after a pc jump is dropped; IDLE re-issues
                    if (mem_addr == pc) begin
                        cur_d = {1'b1, mem_addr, mem_data};
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cur_d   = {1'b1, mem_addr, NOP_INS};
                    state_d = IDLE;
                end
            end
            PREF: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    pf_d    = {1'b1, mem_addr, mem_data};
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            pf_q     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cnt_q    <= '0;
            err      <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pf_q     <= pf_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
            cnt_q    <= cnt_d;
            err      <= err_d;
            hold_q   <= ins_out;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized core and
// memory, checked against a memory image and handshake rules.
module tb_instr_fetch_unit;

    logic       clk;
    logic       CLB;
    logic [7:0] pc;
    logic [7:0] ins_out;
    logic       ins_valid;
    logic       stall;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       err;

    logic [7:0] mem [256];
    int         wait_fixed;
    bit         silent;
    bit         mon_en;
    int         chk_cnt;
    int         pass_cnt;

    instr_fetch_unit dut (
        .clk       (clk),
        .CLB       (CLB),
        .pc        (pc),
        .ins_out   (ins_out),
        .ins_valid (ins_valid),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int c;
        c = 0;
        while (!ins_valid && c < maxc) begin
            step();
            c++;
        end
        check(tag, 32'(ins_valid), 32'd1);
    endtask

    task automatic per_cycle();
        check("stall", 32'(stall), 32'(!ins_valid));
        if (ins_valid) check("data", 32'(ins_out), 32'(mem[pc]));
        check("err", 32'(err), 32'd0);
    endtask

    // Memory model: fixed or random wait states, or never answers when silent
    initial begin
        int  wl;
        bit  active;
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        active   = 1'b0;
        wl       = 0;
        forever begin
            @(negedge clk);
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
            if (!mem_req) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    wl = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
                end
                if (!silent) begin
                    if (wl == 0) begin
                        mem_ack  = 1'b1;
                        mem_data = mem[mem_addr];
                    end else begin
                        wl--;
                    end
                end
            end
        end
    end

    // Handshake rules: drop after ack, no abort, address held while waiting
    initial begin
        logic       prev_req;
        logic [7:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = 8'h00;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en && prev_req) begin
                if (mem_ack) begin
                    check("req_drop", 32'(mem_req), 32'd0);
                end else begin
                    check("no_abort", 32'(mem_req), 32'd1);
                    check("addr_stable", 32'(mem_addr), 32'(prev_addr));
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        chk_cnt    = 0;
        pass_cnt   = 0;
        wait_fixed = 0;
        silent     = 1'b0;
        mon_en     = 1'b0;
        pc         = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h3A;
        mem[8'h01] = 8'h51;
        mem[8'h80] = 8'hA5;
        CLB = 1'b1;
        #1 CLB = 1'b0;

        repeat (3) step();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_ins", 32'(ins_out), 32'd0);
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_err", 32'(err), 32'd0);

        // Cold miss with zero-wait memory
        CLB = 1'b1;
        step();
        check("cold_req", 32'(mem_req), 32'd1);
        check("cold_addr", 32'(mem_addr), 32'h00);
        check("cold_nvalid", 32'(ins_valid), 32'd0);
        step();
        check("cold_valid", 32'(ins_valid), 32'd1);
        check("cold_ins", 32'(ins_out), 32'h3A);
        check("cold_stall", 32'(stall), 32'd0);
        step();
        check("pref_req", 32'(mem_req), 32'd1);
        check("pref_addr", 32'(mem_addr), 32'h01);

        // Sequential hit on the prefetched entry
        step();
        check("pref_done", 32'(mem_req), 32'd0);
        wait_fixed = 3;
        pc = 8'h01;
        #1;
        check("seq_valid", 32'(ins_valid), 32'd1);
        check("seq_ins", 32'(ins_out), 32'h51);
        step();
        check("seq_req", 32'(mem_req), 32'd1);
        check("seq_addr", 32'(mem_addr), 32'h02);

        // Jump while the 8'h02 request waits three cycles
        step();
        pc = 8'h40;
        #1;
        for (int k = 6; k <= 10; k++) begin
            check("jump_nvalid", 32'(ins_valid), 32'd0);
            check("jump_req", 32'(mem_req), 32'(k != 9));
            if (k != 9) check("jump_addr", 32'(mem_addr), (k < 9) ? 32'h02 : 32'h40);
            if (k == 9) wait_fixed = 0;
            step();
        end
        check("jump_valid", 32'(ins_valid), 32'd1);
        check("jump_ins", 32'(ins_out), 32'(mem[8'h40]));

        // Address wrap: 8'hFF prefetches 8'h00
        pc = 8'hFF;
        #1;
        wait_valid(40, "wrap_live");
        check("wrap_ins", 32'(ins_out), 32'(mem[8'hFF]));
        n = 0;
        do begin step(); n++; end while (!mem_req && n < 10);
        check("wrap_pref_addr", 32'(mem_addr), 32'h00);
        n = 0;
        do begin step(); n++; end while (mem_req && n < 10);
        pc = 8'h00;
        #1;
        check("wrap_valid", 32'(ins_valid), 32'd1);
        check("wrap_ins0", 32'(ins_out), 32'h3A);
        n = 0;
        do begin step(); n++; end while (!mem_req && n < 10);
        n = 0;
        do begin step(); n++; end while (mem_req && n < 10);
        check("pre_to_err", 32'(err), 32'd0);

        // Demand timeout substitutes NOP and sets the sticky error
        silent = 1'b1;
        pc = 8'h80;
        #1;
        n = 0;
        while (!mem_req && n < 10) begin step(); n++; end
        n = 0;
        while (mem_req && n < 40) begin n++; step(); end
        check("to_len", 32'(n), 32'd16);
        check("to_valid", 32'(ins_valid), 32'd1);
        check("to_ins", 32'(ins_out), 32'h00);
        check("to_err", 32'(err), 32'd1);
        step();
        check("to_pref_req", 32'(mem_req), 32'd1);
        check("to_pref_addr", 32'(mem_addr), 32'h81);
        check("to_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a request
        CLB = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_valid", 32'(ins_valid), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_stall", 32'(stall), 32'd1);
        step();
        step();
        silent     = 1'b0;
        wait_fixed = -1;
        CLB        = 1'b1;
        mon_en     = 1'b1;

        // Randomized core: sequential steps, jumps and holds
        for (int t = 0; t < 250; t++) begin
            int  r;
            int  c;
            bit  jumped;
            r = int'($urandom_range(0, 99));
            step();
            if (r < 65) pc = pc + 8'd1;
            else if (r < 85) pc = 8'($urandom);
            #1;
            per_cycle();
            c = 0;
            jumped = 1'b0;
            while (!ins_valid && c < 40) begin
                step();
                if (!jumped && $urandom_range(0, 19) == 0) begin
                    pc = 8'($urandom);
                    jumped = 1'b1;
                end
                #1;
                per_cycle();
                c++;
            end
            check("live", 32'(ins_valid), 32'd1);
            repeat ($urandom_range(0, 3)) begin
                step();
                #1;
                per_cycle();
            end
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
